// File: rtl/uart_sched.sv
// UART register-port scheduler: loads the baud divisor, round-robins NREQ TX
// requesters onto the transmitter and drains RX into a valid/ready byte (RX path under UART_SCHED_RX_EN).
module uart_sched #(
  parameter int unsigned NREQ = 2,
  parameter logic [11:0] DIV  = 12'd43
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  input  logic              uart_int,
  output logic [3:0]        io_addr,
  output logic [7:0]        io_wdata,
  output logic              io_write,
  output logic              io_read,
  input  logic [7:0]        io_rdata
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_DIVLO,
    S_DIVHI,
    S_IDLE,
    S_TXWR,
    S_STAT,
    S_CLRX,
    S_RXRD,
    S_CLRR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic            w_found;
  logic            r_tx_busy;
  logic            w_rx_valid;
  logic [7:0]      w_req_byte;
  logic            w_req_take;
  logic [NREQ-1:0] w_sel;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!w_found && req_valid[j] && (j == (32'(r_ptr) + k) % NREQ)) begin
          w_found   = 1'b1;
          w_gnt_idx = PW'(j);
        end
      end
    end
  end

  // Latched grant: its byte, its still-valid flag and its one-hot ready.
  always_comb begin
    w_req_byte = '0;
    w_req_take = 1'b0;
    w_sel      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (PW'(k) == r_gnt) begin
        w_req_byte = req_data[8*k +: 8];
        w_req_take = req_valid[k];
        w_sel[k]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_DIVLO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    io_write  = 1'b0;
    io_read   = 1'b0;
    io_addr   = '0;
    io_wdata  = '0;
    req_ready = '0;
    case (r_state)
      S_DIVLO: begin
        io_write = 1'b1;
        io_addr  = 4'd4;
        io_wdata = DIV[7:0];
        w_next   = S_DIVHI;
      end
      S_DIVHI: begin
        io_write = 1'b1;
        io_addr  = 4'd5;
        io_wdata = {4'b0000, DIV[11:8]};
        w_next   = S_IDLE;
      end
      S_IDLE: begin
        if (uart_int && (r_tx_busy || !w_rx_valid)) w_next = S_STAT;
        else if (!r_tx_busy && w_found)            w_next = S_TXWR;
      end
      S_TXWR: begin
        w_next = S_IDLE;
        // A requester that dropped valid after being granted simply forfeits the slot.
        if (w_req_take) begin
          io_write  = 1'b1;
          io_addr   = 4'd1;
          io_wdata  = w_req_byte;
          req_ready = w_sel;
        end
      end
      S_STAT: begin
        io_read = 1'b1;
        io_addr = 4'd2;
        if (io_rdata[0]) w_next = S_CLRX;
`ifdef UART_SCHED_RX_EN
        else if (io_rdata[1] && !w_rx_valid) w_next = S_RXRD;
`else
        else if (io_rdata[1]) w_next = S_CLRR;
`endif
        else w_next = S_IDLE;
      end
      S_CLRX: begin
        io_write = 1'b1;
        io_addr  = 4'd2;
        io_wdata = 8'h01;
        w_next   = S_IDLE;
      end
      S_RXRD: begin
        io_read = 1'b1;
        io_addr = 4'd0;
        w_next  = S_IDLE;
      end
      S_CLRR: begin
        io_write = 1'b1;
        io_addr  = 4'd2;
        io_wdata = 8'h02;
        w_next   = S_IDLE;
      end
      default: w_next = S_DIVLO;
    endcase
    if (reset) begin
      io_write  = 1'b0;
      io_read   = 1'b0;
      io_addr   = '0;
      io_wdata  = '0;
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_tx_busy <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_next == S_TXWR) r_gnt <= w_gnt_idx;
      if (r_state == S_TXWR && w_req_take) begin
        r_ptr     <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
        r_tx_busy <= 1'b1;
      end
      if (r_state == S_CLRX) r_tx_busy <= 1'b0;
    end
  end

  assign busy = r_tx_busy && !reset;

`ifdef UART_SCHED_RX_EN
  logic       r_rx_valid;
  logic [7:0] r_rx_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else if (r_state == S_RXRD) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= io_rdata;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign w_rx_valid = r_rx_valid;
  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
`else
  logic w_unused_rx;

  assign w_unused_rx = ^{rx_ready, io_rdata[7:2]};
  assign w_rx_valid  = 1'b0;
  assign rx_valid    = 1'b0;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_uart_sched.sv
// Scoreboard bench for uart_sched: expected bus cycles are queued as stimulus is
// driven and compared against every strobe the DUT issues.
module tb_uart_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        busy;
  logic        uart_int = 1'b0;
  logic [3:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_write;
  logic        io_read;
  logic [7:0]  io_rdata;

  logic [7:0]  m_status = '0;
  logic [7:0]  m_rxbyte = '0;
  int          n_err = 0;
  int          n_chk = 0;
  int          m_ptr = 0;
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  uart_sched #(.NREQ(2), .DIV(12'd43)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .uart_int  (uart_int),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_write  (io_write),
    .io_read   (io_read),
    .io_rdata  (io_rdata)
  );

  always_comb begin
    io_rdata = 8'h00;
    if (io_addr == 4'd2)      io_rdata = m_status;
    else if (io_addr == 4'd0) io_rdata = m_rxbyte;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (io_write || io_read) begin
      if (exp_q.size() == 0) check("unexpected_strobe", {io_write, io_read, io_addr, io_wdata}, 32'd0);
      else                   check("bus", {io_write, io_read, io_addr, io_wdata}, exp_q.pop_front());
    end else begin
      check("idle_bus", {io_addr, io_wdata}, 32'd0);
    end
    check("ready_only_on_txwr", {31'd0, |req_ready}, {31'd0, io_write && io_addr == 4'd1});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({w, r, a, d});
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      tick();
      t++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  function automatic int rr(input logic [1:0] m, input int p);
    for (int k = 0; k < 2; k++) begin
      int i = (p + k) % 2;
      if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic tx_one(input string tag, output int lat);
    int g;
    int t = 0;
    g = rr(req_valid, m_ptr);
    push(1'b1, 1'b0, 4'd1, req_data[8*g +: 8]);
    do begin
      tick();
      t++;
    end while (req_ready == 2'b00 && t < 20);
    lat = t;
    check({tag, "_ready"}, req_ready, 2'b01 << g);
    tick();
    req_valid[g] = 1'b0;
    check({tag, "_busy"}, busy, 1);
    m_ptr = (g + 1) % 2;
  endtask

  task automatic clear_xint(input string tag);
    push(1'b0, 1'b1, 4'd2, 8'h00);
    push(1'b1, 1'b0, 4'd2, 8'h01);
    m_status = 8'h01;
    uart_int = 1'b1;
    drain({tag, "_drain"});
    uart_int = 1'b0;
    m_status = 8'h00;
    check({tag, "_busy_clear"}, busy, 0);
  endtask

  task automatic reset_release();
    push(1'b1, 1'b0, 4'd4, 8'h2B);
    push(1'b1, 1'b0, 4'd5, 8'h00);
    reset = 1'b0;
    m_ptr = 0;
    drain("divisor_load");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rx_valid", rx_valid, 0);

    reset_release();
    repeat (6) tick();
    check("idle_quiet", exp_q.size(), 0);

    // Single requester from idle: ready lands in the second cycle of valid.
    req_data[7:0] = 8'h55;
    req_valid     = 2'b01;
    check("ready_not_early", req_ready, 0);
    tx_one("tx55", lat);
    check("tx55_latency", lat, 1);
    clear_xint("x1");

    // Both requesting; pointer already moved past requester 0.
    req_data  = {8'hB2, 8'hA1};
    req_valid = 2'b11;
    tx_one("rr_first", lat);
    clear_xint("x2");
    tx_one("rr_second", lat);
    clear_xint("x3");

`ifdef UART_SCHED_RX_EN
    push(1'b0, 1'b1, 4'd2, 8'h00);
    push(1'b0, 1'b1, 4'd0, 8'h00);
    m_status = 8'h02;
    m_rxbyte = 8'h3C;
    uart_int = 1'b1;
    drain("rx1_drain");
    check("rx1_valid", rx_valid, 1);
    check("rx1_data", rx_data, 8'h3C);
    repeat (8) tick();
    check("rx_hold_valid", rx_valid, 1);
    check("rx_hold_data", rx_data, 8'h3C);

    m_rxbyte = 8'h7E;
    push(1'b0, 1'b1, 4'd2, 8'h00);
    push(1'b0, 1'b1, 4'd0, 8'h00);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx1_consumed", rx_valid, 0);
    drain("rx2_drain");
    check("rx2_valid", rx_valid, 1);
    check("rx2_data", rx_data, 8'h7E);
    uart_int = 1'b0;
    m_status = 8'h00;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx2_consumed", rx_valid, 0);
`else
    push(1'b0, 1'b1, 4'd2, 8'h00);
    push(1'b1, 1'b0, 4'd2, 8'h02);
    m_status = 8'h02;
    uart_int = 1'b1;
    drain("clrr_drain");
    uart_int = 1'b0;
    m_status = 8'h00;
    check("norx_valid", rx_valid, 0);
    check("norx_data", rx_data, 0);
`endif
    repeat (4) tick();

    // Reset landing on the TX write cycle must suppress that strobe entirely.
    req_data[7:0] = 8'h55;
    req_valid     = 2'b01;
    tick();
    check("txwr_reached", {io_write, io_addr}, {1'b1, 4'd1});
    reset = 1'b1;
    #1;
    check("rst_txwr_ready", req_ready, 0);
    check("rst_txwr_write", io_write, 0);
    check("rst_txwr_busy", busy, 0);
    req_valid = 2'b00;
    tick();
    tick();
    reset_release();
    repeat (3) tick();

    // Pointer restarts at 0 after reset.
    req_data  = {8'hC4, 8'hD3};
    req_valid = 2'b11;
    tx_one("post_rst_first", lat);
    clear_xint("x4");
    tx_one("post_rst_second", lat);
    clear_xint("x5");
    repeat (4) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
